ub_dma_master: RTL and testbench
================================

Name: ub_dma_master

Overview:
- Initiator-side engine for the unified buffer's read/write port.
- Accepts one transfer command: direction, bank, start address, length.
- Write direction: streams DATA_WIDTH-bit words from an input valid/ready stream into the buffer, one word per access.
- Read direction: fetches buffer words one per access and presents them on an output valid/ready stream.
- Sits between the UART/host loader and the buffer; owns the ub_rd_* and ub_wr_* request lines.

Parameters:
- DATA_WIDTH, 256, buffer word width.
- ADDR_WIDTH, 8, in-bank address width; buffer address is ADDR_WIDTH+1 bits, MSB is the bank select.
- RD_TIMEOUT, 8, cycles to wait for ub_rd_valid before flagging an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high in IDLE only
- cmd_dir  in  1  0 = write into buffer, 1 = read from buffer
- cmd_bank  in  1  bank select, fixed for the whole transfer
- cmd_addr  in  ADDR_WIDTH  start word address
- cmd_len  in  ADDR_WIDTH+1  word count, 0..256
- in_data  in  DATA_WIDTH  write stream data
- in_valid  in  1  write stream valid
- in_ready  out  1  write stream ready
- out_data  out  DATA_WIDTH  read stream data
- out_valid  out  1  read stream valid
- out_ready  in  1  read stream ready
- ub_rd_en  out  1  read request
- ub_rd_addr  out  ADDR_WIDTH+1  read address
- ub_rd_count  out  ADDR_WIDTH+1  read count, always 1
- ub_rd_data  in  DATA_WIDTH  read data
- ub_rd_valid  in  1  read data valid
- ub_wr_en  out  1  write request
- ub_wr_addr  out  ADDR_WIDTH+1  write address
- ub_wr_count  out  ADDR_WIDTH+1  write count, always 1
- ub_wr_data  out  DATA_WIDTH  write data
- ub_wr_ready  in  1  buffer write ready
- ub_busy  in  1  buffer busy
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on rejected or aborted transfer
- words_done  out  ADDR_WIDTH+1  words completed in the current or last transfer

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0 except cmd_ready = 1; ub_*_count = 1 at all times.
- States: IDLE, WR_DATA, WR_GAP, RD_ISSUE, RD_WAIT, RD_OUT, FINISH.
- Buffer accesses always use count 1. Buffer burst modes are not used: burst writes repeat the latched data, and the final burst read word lacks valid.
- Enable timing: ub_rd_en and ub_wr_en are single-cycle pulses. Address and data are stable in the pulse cycle.
- Address arithmetic: in-bank address is ADDR_WIDTH bits and increments per word, wrapping 255 -> 0. Bank bit is constant for the transfer.
- IDLE:
  - cmd_valid with cmd_len > 256 -> err pulse, stay IDLE.
  - cmd_len = 0 -> done pulse next cycle, no bus activity.
  - Otherwise latch the command, clear words_done, go to WR_DATA (dir 0) or RD_ISSUE (dir 1).
- WR_DATA:
  - in_ready = ub_wr_ready.
  - On in_valid & in_ready: register ub_wr_data and ub_wr_addr, assert ub_wr_en next cycle, go to WR_GAP.
- WR_GAP:
  - ub_wr_en is high this cycle only; words_done increments.
  - Last word -> FINISH; else -> WR_DATA.
  - Maximum rate is 1 word per 2 cycles.
- RD_ISSUE:
  - Only entered with out_valid = 0.
  - Assert ub_rd_en next cycle with the current address, reset the timeout counter, go to RD_WAIT.
- RD_WAIT:
  - On ub_rd_valid: capture ub_rd_data into out_data, set out_valid, go to RD_OUT.
  - On reaching RD_TIMEOUT cycles without ub_rd_valid: err pulse, go to IDLE, no done.
- RD_OUT:
  - On out_valid & out_ready: clear out_valid, increment words_done.
  - Last word -> done pulse, go to IDLE; else -> RD_ISSUE.
- FINISH: wait for ub_busy = 0, then done pulse and go to IDLE.
- in_valid outside WR_DATA is ignored (in_ready = 0). out_data holds its value until the handshake completes.
- Reset mid-transfer: next cycle state is IDLE, enables low, out_valid low, partial data discarded, no done or err pulse.

Test Plan:
- Write: bank 0, addr 0x10, len 4, words A..D offered back-to-back -> ub_wr_en pulses every 2nd cycle at addresses 0x010..0x013 with data A..D; done after ub_busy falls; words_done = 4.
- Read: bank 1, addr 0x20, len 3, out_ready held 1 -> ub_rd_addr 0x120..0x122, each pulse count = 1; out_data matches buffer contents in order; done once; out_valid never high while ub_rd_en is pending.
- Wrap: write bank 1, addr 0xFE, len 3 -> addresses 0x1FE, 0x1FF, 0x100.
- Backpressure and throttling: read len 2 with out_ready low for 10 cycles -> no second ub_rd_en until the first word is accepted. Write with in_valid gaps -> no ub_wr_en during gaps.
- Errors: cmd_len 300 -> err pulse, no bus activity. Read with ub_rd_valid forced 0 -> err exactly RD_TIMEOUT cycles after the ub_rd_en pulse. cmd_len 0 -> done pulse only.
- Reset mid-read after 1 of 4 words -> IDLE, cmd_ready = 1, out_valid = 0, no done; a new command then completes normally.

Source files
------------

// File: rtl/ub_dma_master.sv
// ub_dma_master: single-command DMA engine between the host streams and the unified buffer.
// Each word costs one count-1 buffer access, either written from in_* or read out to out_*.
module ub_dma_master #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_dir_i,
    input  logic                  cmd_bank_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH:0]   cmd_len_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  ub_rd_en_o,
    output logic [ADDR_WIDTH:0]   ub_rd_addr_o,
    output logic [ADDR_WIDTH:0]   ub_rd_count_o,
    input  logic [DATA_WIDTH-1:0] ub_rd_data_i,
    input  logic                  ub_rd_valid_i,
    output logic                  ub_wr_en_o,
    output logic [ADDR_WIDTH:0]   ub_wr_addr_o,
    output logic [ADDR_WIDTH:0]   ub_wr_count_o,
    output logic [DATA_WIDTH-1:0] ub_wr_data_o,
    input  logic                  ub_wr_ready_i,
    input  logic                  ub_busy_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   words_done_o
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [TW-1:0] TIMER_LAST = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_GAP,
        RD_ISSUE,
        RD_WAIT,
        RD_OUT,
        FINISH
    } state_t;

    state_t                  state_q;
    logic                    bank_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     words_done_q;
    logic [ADDR_WIDTH:0]     words_done_d;
    logic                    last_word;
    logic [TW-1:0]           timer_q;
    logic                    cmd_ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic                    ub_wr_en_q;
    logic                    ub_rd_en_q;
    logic [ADDR_WIDTH:0]     ub_wr_addr_q;
    logic [ADDR_WIDTH:0]     ub_rd_addr_q;
    logic [DATA_WIDTH-1:0]   ub_wr_data_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_valid_q;

    assign words_done_d = words_done_q + 1'b1;
    assign last_word    = (words_done_d == len_q);

    // The write stream is throttled directly by the buffer's write readiness.
    assign in_ready_o    = (state_q == WR_DATA) && ub_wr_ready_i;
    assign cmd_ready_o   = cmd_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign words_done_o  = words_done_q;
    assign ub_wr_en_o    = ub_wr_en_q;
    assign ub_rd_en_o    = ub_rd_en_q;
    assign ub_wr_addr_o  = ub_wr_addr_q;
    assign ub_rd_addr_o  = ub_rd_addr_q;
    assign ub_wr_data_o  = ub_wr_data_q;
    assign out_data_o    = out_data_q;
    assign out_valid_o   = out_valid_q;
    assign ub_rd_count_o = {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign ub_wr_count_o = {{ADDR_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            bank_q       <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            timer_q      <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ub_wr_en_q   <= 1'b0;
            ub_rd_en_q   <= 1'b0;
            ub_wr_addr_q <= '0;
            ub_rd_addr_q <= '0;
            ub_wr_data_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ub_wr_en_q <= 1'b0;
            ub_rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_len_i > MAX_LEN) begin
                            err_q <= 1'b1;
                        end else if (cmd_len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            bank_q       <= cmd_bank_i;
                            addr_q       <= cmd_addr_i;
                            len_q        <= cmd_len_i;
                            words_done_q <= '0;
                            cmd_ready_q  <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= cmd_dir_i ? RD_ISSUE : WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (in_valid_i && in_ready_o) begin
                        ub_wr_data_q <= in_data_i;
                        ub_wr_addr_q <= {bank_q, addr_q};
                        ub_wr_en_q   <= 1'b1;
                        addr_q       <= addr_q + 1'b1;
                        state_q      <= WR_GAP;
                    end
                end
                WR_GAP: begin
                    words_done_q <= words_done_d;
                    state_q      <= last_word ? FINISH : WR_DATA;
                end
                FINISH: begin
                    if (!ub_busy_i) begin
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    ub_rd_en_q   <= 1'b1;
                    ub_rd_addr_q <= {bank_q, addr_q};
                    addr_q       <= addr_q + 1'b1;
                    timer_q      <= '0;
                    state_q      <= RD_WAIT;
                end
                RD_WAIT: begin
                    // The timer starts in the request pulse cycle, so err lands RD_TIMEOUT cycles after it.
                    if (ub_rd_valid_i) begin
                        out_data_q  <= ub_rd_data_i;
                        out_valid_q <= 1'b1;
                        state_q     <= RD_OUT;
                    end else if (timer_q == TIMER_LAST) begin
                        err_q       <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RD_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q  <= 1'b0;
                        words_done_q <= words_done_d;
                        if (last_word) begin
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ub_dma_master.sv
// Self-checking bench for ub_dma_master: a buffer/stream agent logs bus traffic and a
// word-level model (address arithmetic plus a reference memory) predicts every transfer.
module tb_ub_dma_master;

    localparam int DW = 256;
    localparam int AW = 8;
    localparam int RT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_dir, cmd_bank;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] in_data, out_data, ub_rd_data, ub_wr_data;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic          ub_rd_en, ub_rd_valid, ub_wr_en, ub_wr_ready, ub_busy;
    logic [AW:0]   ub_rd_addr, ub_rd_count, ub_wr_addr, ub_wr_count, words_done;
    logic          busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem    [512];
    logic [DW-1:0] refMem [512];

    logic [AW:0]   wrAddrQ[$];
    logic [DW-1:0] wrDataQ[$];
    int            wrCycQ[$];
    logic [AW:0]   rdAddrQ[$];
    int            rdCycQ[$];
    logic [DW-1:0] outDataQ[$];
    logic [DW-1:0] srcQ[$];

    int cycle = 0, doneCnt = 0, errCnt = 0, errCyc = 0, lastAccCyc = -10;
    bit gapMode = 1'b0, rdMute = 1'b0, randReady = 1'b0;
    int holdCnt = 0;

    int            rdPend = 0, busyCnt = 0, lat = 0;
    logic [AW:0]   rdPendAddr = '0;
    bit            prevValid = 1'b0, rdOutstanding = 1'b0, prevBusy = 1'b0, accepted = 1'b0;
    logic [DW-1:0] prevData = '0;

    int wb, rb, ob, d0, e0, n;

    always #5 clk = ~clk;

    ub_dma_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(RT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_dir_i(cmd_dir),
        .cmd_bank_i(cmd_bank), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .ub_rd_en_o(ub_rd_en), .ub_rd_addr_o(ub_rd_addr), .ub_rd_count_o(ub_rd_count),
        .ub_rd_data_i(ub_rd_data), .ub_rd_valid_i(ub_rd_valid),
        .ub_wr_en_o(ub_wr_en), .ub_wr_addr_o(ub_wr_addr), .ub_wr_count_o(ub_wr_count),
        .ub_wr_data_o(ub_wr_data), .ub_wr_ready_i(ub_wr_ready), .ub_busy_i(ub_busy),
        .busy_o(busy), .done_o(done), .err_o(err), .words_done_o(words_done)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Buffer responder and stream endpoints; runs just after each falling edge.
    initial begin : busAgent
        forever begin
            @(negedge clk);
            #1;
            cycle++;
            prevBusy = ub_busy;
            if (rst) begin
                rdPend = 0; busyCnt = 0; ub_rd_valid = 1'b0; ub_busy = 1'b0;
                prevValid = 1'b0; rdOutstanding = 1'b0; in_valid = 1'b0;
            end else begin
                if (done) begin
                    doneCnt++;
                    checkOutput("done_while_ub_busy", DW'(prevBusy), DW'(1'b0));
                end
                if (err) begin
                    errCnt++;
                    errCyc = cycle;
                    rdOutstanding = 1'b0;
                end
                if (prevValid) begin
                    checkOutput("out_valid_held", DW'(out_valid), DW'(1'b1));
                    checkOutput("out_data_held", out_data, prevData);
                end
                ub_rd_valid = 1'b0;
                if (rdPend > 0) begin
                    rdPend--;
                    if (rdPend == 0) begin
                        ub_rd_valid = 1'b1;
                        ub_rd_data  = mem[rdPendAddr];
                    end
                end
                if (ub_wr_en) begin
                    checkOutput("wr_count", DW'(ub_wr_count), DW'(1));
                    checkOutput("wr_follows_accept", DW'(cycle - lastAccCyc), DW'(1));
                    wrAddrQ.push_back(ub_wr_addr);
                    wrDataQ.push_back(ub_wr_data);
                    wrCycQ.push_back(cycle);
                    mem[ub_wr_addr] = ub_wr_data;
                    busyCnt = $urandom_range(1, 3);
                end
                if (ub_rd_en) begin
                    checkOutput("rd_count", DW'(ub_rd_count), DW'(1));
                    checkOutput("rd_while_out_valid", DW'(out_valid), DW'(1'b0));
                    checkOutput("rd_before_accept", DW'(rdOutstanding), DW'(1'b0));
                    rdOutstanding = 1'b1;
                    rdAddrQ.push_back(ub_rd_addr);
                    rdCycQ.push_back(cycle);
                    if (!rdMute) begin
                        lat = $urandom_range(0, 2);
                        rdPendAddr = ub_rd_addr;
                        if (lat == 0) begin
                            ub_rd_valid = 1'b1;
                            ub_rd_data  = mem[ub_rd_addr];
                        end else begin
                            rdPend = lat;
                        end
                    end
                end
                if (busyCnt > 0) begin
                    ub_busy = 1'b1;
                    busyCnt--;
                end else begin
                    ub_busy = 1'b0;
                end
                if (holdCnt > 0) begin
                    out_ready = 1'b0;
                    holdCnt--;
                end else begin
                    out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                accepted = out_valid && out_ready;
                if (accepted) begin
                    outDataQ.push_back(out_data);
                    rdOutstanding = 1'b0;
                end
                prevValid = out_valid && !accepted;
                prevData  = out_data;
                if (srcQ.size() > 0) begin
                    in_valid = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
                    in_data  = srcQ[0];
                    if (in_valid && in_ready) begin
                        lastAccCyc = cycle;
                        void'(srcQ.pop_front());
                    end
                end else begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = randWord();
                    if (in_valid) checkOutput("in_ready_outside_write", DW'(in_ready), DW'(1'b0));
                end
            end
        end
    end

    task automatic applyStimulus(input bit dir, input bit bank, input logic [AW-1:0] addr,
                                 input int len);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_bank  = bank;
        cmd_addr  = addr;
        cmd_len   = (AW+1)'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitEnd(input int dStart, input int eStart, input int limit);
        int k;
        k = 0;
        while (doneCnt == dStart && errCnt == eStart && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) checkOutput("end_timeout", DW'(1), DW'(0));
    endtask

    // One complete transfer, predicted word by word from start address, length and bank.
    task automatic runTransfer(input bit dir, input bit bank, input logic [AW-1:0] addr,
                               input int len);
        int wBase, rBase, oBase, dStart, eStart;
        logic [AW-1:0] inb;
        logic [AW:0]   a;
        logic [DW-1:0] words[$];
        wBase = wrAddrQ.size(); rBase = rdAddrQ.size(); oBase = outDataQ.size();
        dStart = doneCnt; eStart = errCnt;
        if (!dir) begin
            for (int i = 0; i < len; i++) begin
                words.push_back(randWord());
                srcQ.push_back(words[i]);
            end
        end
        applyStimulus(dir, bank, addr, len);
        waitEnd(dStart, eStart, 4000);
        @(negedge clk);
        checkOutput("done_count", DW'(doneCnt - dStart), DW'(1));
        checkOutput("err_count", DW'(errCnt - eStart), DW'(0));
        checkOutput("words_done", DW'(words_done), DW'(len));
        checkOutput("cmd_ready_after", DW'(cmd_ready), DW'(1'b1));
        checkOutput("busy_after", DW'(busy), DW'(1'b0));
        checkOutput("wr_pulses", DW'(wrAddrQ.size() - wBase), dir ? DW'(0) : DW'(len));
        checkOutput("rd_pulses", DW'(rdAddrQ.size() - rBase), dir ? DW'(len) : DW'(0));
        for (int i = 0; i < len; i++) begin
            inb = addr + AW'(i);
            a   = {bank, inb};
            if (!dir) begin
                if (wBase + i < wrAddrQ.size()) begin
                    checkOutput("wr_addr", DW'(wrAddrQ[wBase+i]), DW'(a));
                    checkOutput("wr_data", wrDataQ[wBase+i], words[i]);
                end
                refMem[a] = words[i];
            end else begin
                if (rBase + i < rdAddrQ.size())
                    checkOutput("rd_addr", DW'(rdAddrQ[rBase+i]), DW'(a));
                if (oBase + i < outDataQ.size())
                    checkOutput("out_data", outDataQ[oBase+i], refMem[a]);
            end
        end
        if (dir) checkOutput("out_words", DW'(outDataQ.size() - oBase), DW'(len));
    endtask

    initial begin : main
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_bank = 1'b0; cmd_addr = '0;
        cmd_len = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; ub_rd_data = '0;
        ub_rd_valid = 1'b0; ub_wr_ready = 1'b1; ub_busy = 1'b0;
        for (int i = 0; i < 512; i++) begin
            mem[i]    = randWord();
            refMem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_ready", DW'(cmd_ready), DW'(1'b1));
        checkOutput("rst_busy", DW'(busy), DW'(1'b0));
        checkOutput("rst_done", DW'(done), DW'(1'b0));
        checkOutput("rst_err", DW'(err), DW'(1'b0));
        checkOutput("rst_out_valid", DW'(out_valid), DW'(1'b0));
        checkOutput("rst_rd_en", DW'(ub_rd_en), DW'(1'b0));
        checkOutput("rst_wr_en", DW'(ub_wr_en), DW'(1'b0));
        checkOutput("rst_rd_count", DW'(ub_rd_count), DW'(1));
        checkOutput("rst_wr_count", DW'(ub_wr_count), DW'(1));
        checkOutput("rst_words_done", DW'(words_done), DW'(0));
        checkOutput("rst_in_ready", DW'(in_ready), DW'(1'b0));

        $display("[TB] back-to-back write, read, wrap");
        wb = wrAddrQ.size();
        runTransfer(1'b0, 1'b0, 8'h10, 4);
        for (int i = 0; i < 3; i++)
            if (wb + i + 1 < wrCycQ.size())
                checkOutput("wr_spacing", DW'(wrCycQ[wb+i+1] - wrCycQ[wb+i]), DW'(2));
        runTransfer(1'b1, 1'b1, 8'h20, 3);
        runTransfer(1'b0, 1'b1, 8'hFE, 3);

        $display("[TB] read backpressure and write gaps");
        rb = rdAddrQ.size();
        holdCnt = 10;
        runTransfer(1'b1, 1'b0, 8'h10, 2);
        if (rb + 1 < rdCycQ.size())
            checkOutput("bp_no_early_rd", DW'((rdCycQ[rb+1] - rdCycQ[rb]) >= 10), DW'(1'b1));
        gapMode = 1'b1;
        runTransfer(1'b0, 1'b0, 8'h30, 6);
        gapMode = 1'b0;

        $display("[TB] error cases");
        wb = wrAddrQ.size(); rb = rdAddrQ.size(); d0 = doneCnt; e0 = errCnt;
        applyStimulus(1'b0, 1'b0, 8'h00, 300);
        checkOutput("len300_err", DW'(err), DW'(1'b1));
        checkOutput("len300_no_done", DW'(done), DW'(1'b0));
        checkOutput("len300_cmd_ready", DW'(cmd_ready), DW'(1'b1));
        repeat (3) @(negedge clk);
        checkOutput("len300_err_once", DW'(errCnt - e0), DW'(1));
        applyStimulus(1'b1, 1'b1, 8'h05, 0);
        checkOutput("len0_done", DW'(done), DW'(1'b1));
        checkOutput("len0_no_err", DW'(err), DW'(1'b0));
        repeat (3) @(negedge clk);
        checkOutput("len0_done_once", DW'(doneCnt - d0), DW'(1));
        checkOutput("err_cases_no_wr", DW'(wrAddrQ.size() - wb), DW'(0));
        checkOutput("err_cases_no_rd", DW'(rdAddrQ.size() - rb), DW'(0));
        checkOutput("err_cases_busy", DW'(busy), DW'(1'b0));

        rb = rdAddrQ.size(); d0 = doneCnt; e0 = errCnt;
        rdMute = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h80, 2);
        waitEnd(d0, e0, 200);
        @(negedge clk);
        rdMute = 1'b0;
        checkOutput("timeout_err", DW'(errCnt - e0), DW'(1));
        checkOutput("timeout_no_done", DW'(doneCnt - d0), DW'(0));
        checkOutput("timeout_rd_pulses", DW'(rdAddrQ.size() - rb), DW'(1));
        if (rb < rdCycQ.size())
            checkOutput("timeout_latency", DW'(errCyc - rdCycQ[rb]), DW'(RT));
        checkOutput("timeout_cmd_ready", DW'(cmd_ready), DW'(1'b1));

        $display("[TB] reset during a read");
        ob = outDataQ.size(); d0 = doneCnt; e0 = errCnt;
        applyStimulus(1'b1, 1'b0, 8'h40, 4);
        n = 0;
        while (outDataQ.size() < ob + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_mid_first_word", DW'(outDataQ.size() - ob), DW'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_cmd_ready", DW'(cmd_ready), DW'(1'b1));
        checkOutput("rst_mid_out_valid", DW'(out_valid), DW'(1'b0));
        checkOutput("rst_mid_busy", DW'(busy), DW'(1'b0));
        checkOutput("rst_mid_rd_en", DW'(ub_rd_en), DW'(1'b0));
        checkOutput("rst_mid_done", DW'(done), DW'(1'b0));
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_no_done", DW'(doneCnt - d0), DW'(0));
        checkOutput("rst_mid_no_err", DW'(errCnt - e0), DW'(0));
        runTransfer(1'b1, 1'b0, 8'h40, 2);

        $display("[TB] full-length and randomized transfers");
        randReady = 1'b1;
        runTransfer(1'b0, 1'b1, 8'h05, 256);
        runTransfer(1'b1, 1'b1, 8'h05, 256);
        for (int t = 0; t < 12; t++) begin
            gapMode = 1'($urandom_range(0, 1));
            runTransfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 255)), $urandom_range(1, 24));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
